// File: rtl/or_gate_db_pkg.sv
// Shared constants and helpers for the or_gate_db block.
package or_gate_db_pkg;

   localparam int DEF_WIDTH = 1;
   localparam int DEF_CNT_W = 8;

   // All-ones value of a cnt_w-bit counter; used as the saturation ceiling.
   function automatic logic [31:0] sat_val(input int cnt_w);
      if (cnt_w >= 32) return '1;
      return (32'd1 << cnt_w) - 32'd1;
   endfunction

endpackage

// File: rtl/or_gate_db_edge_cnt.sv
// Rising-edge detector on z_any plus a saturating event counter with
// synchronous clear (clear wins over a coincident rise).
module or_gate_db_edge_cnt
   import or_gate_db_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             z_any,
   input  logic             out_valid,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] rise_cnt
);

   localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));

   logic z_any_prev;
   logic rise;

   // Only qualified results can register a 0->1 event.
   assign rise = out_valid & z_any & ~z_any_prev;

   // History of z_any and the saturating counter; reset forces prev=0 so the
   // first edge after release sees a clean baseline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         z_any_prev <= 1'b0;
         rise_cnt   <= '0;
      end else begin
         z_any_prev <= z_any;
         if (clr_cnt)
            rise_cnt <= '0;
         else if (rise && (rise_cnt != SAT))
            rise_cnt <= rise_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/or_gate_db.sv
// Bitwise two-input OR with optional output register, valid tracking and a
// saturating count of rising edges on the reduced result.
module or_gate_db
   import or_gate_db_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int OUT_REG = 0,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] z,
   output logic             out_valid,
   output logic             z_any,
   output logic [CNT_W-1:0] rise_cnt,
   input  logic             clr_cnt
);

   logic [WIDTH-1:0] or_val;

   assign or_val = x | y;

   generate
      if (OUT_REG != 0) begin : g_reg
         logic [WIDTH-1:0] z_q;
         logic             vld_q;

         // Capture qualified results only; hold z while in_valid is low.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               z_q   <= '0;
               vld_q <= 1'b0;
            end else begin
               if (in_valid) z_q <= or_val;
               vld_q <= in_valid;
            end
         end

         assign z         = z_q;
         assign out_valid = vld_q;
      end else begin : g_comb
         // Pure combinational path: unaffected by clk, rst_n or in_valid.
         assign z         = or_val;
         assign out_valid = in_valid;
      end
   endgenerate

   assign z_any = |z;

   or_gate_db_edge_cnt #(
      .CNT_W (CNT_W)
   ) u_edge_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .z_any     (z_any),
      .out_valid (out_valid),
      .clr_cnt   (clr_cnt),
      .rise_cnt  (rise_cnt)
   );

endmodule

// File: tb/tb_or_gate_db.sv
// Self-checking bench: a default (combinational) instance and a registered
// 4-bit instance with a 2-bit counter, checked against a behavioural model.
module tb_or_gate_db;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // combinational instance (defaults)
   logic       c_vld = 1'b0, c_x = 1'b0, c_y = 1'b0, c_clr = 1'b0;
   logic       c_z, c_ov, c_zany;
   logic [7:0] c_cnt;

   // registered instance
   logic       r_vld = 1'b0, r_clr = 1'b0;
   logic [3:0] r_x = '0, r_y = '0;
   logic [3:0] r_z;
   logic       r_ov, r_zany;
   logic [1:0] r_cnt;

   or_gate_db u_comb (
      .clk(clk), .rst_n(rst_n), .in_valid(c_vld), .x(c_x), .y(c_y),
      .z(c_z), .out_valid(c_ov), .z_any(c_zany), .rise_cnt(c_cnt), .clr_cnt(c_clr)
   );

   or_gate_db #(.WIDTH(4), .OUT_REG(1), .CNT_W(2)) u_reg (
      .clk(clk), .rst_n(rst_n), .in_valid(r_vld), .x(r_x), .y(r_y),
      .z(r_z), .out_valid(r_ov), .z_any(r_zany), .rise_cnt(r_cnt), .clr_cnt(r_clr)
   );

   int n_vec = 0;
   int n_err = 0;

   // model state
   int       mc_cnt = 0;
   bit       mc_prev = 0;
   bit [3:0] mr_z = '0;
   bit       mr_ov = 0;
   bit       mr_prev = 0;
   int       mr_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mc_cnt = 0; mc_prev = 0;
      mr_z = '0; mr_ov = 0; mr_prev = 0; mr_cnt = 0;
   endtask

   // What each instance should do at a clock edge, from the values just before it.
   task automatic model_edge();
      bit any;
      any = (c_x | c_y) != 0;
      if (c_clr) mc_cnt = 0;
      else if (c_vld && any && !mc_prev && mc_cnt < 255) mc_cnt++;
      mc_prev = any;

      any = (mr_z != 0);
      if (r_clr) mr_cnt = 0;
      else if (mr_ov && any && !mr_prev && mr_cnt < 3) mr_cnt++;
      mr_prev = any;
      if (r_vld) mr_z = r_x | r_y;
      mr_ov = r_vld;
   endtask

   task automatic check_all();
      chk("c_z",    32'(c_z),    32'(c_x | c_y));
      chk("c_zany", 32'(c_zany), 32'((c_x | c_y) != 0));
      chk("c_ov",   32'(c_ov),   32'(c_vld));
      chk("c_cnt",  32'(c_cnt),  32'(mc_cnt));
      chk("r_z",    32'(r_z),    32'(mr_z));
      chk("r_zany", 32'(r_zany), 32'(mr_z != 0));
      chk("r_ov",   32'(r_ov),   32'(mr_ov));
      chk("r_cnt",  32'(r_cnt),  32'(mr_cnt));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      // combinational truth table while reset is held (z must still follow x|y)
      for (int i = 0; i < 4; i++) begin
         {c_x, c_y} = 2'(i);
         #1;
         chk("tt_z", 32'(c_z), (i == 0) ? 32'd0 : 32'd1);
         #9;
      end
      chk("rst_r_z",   32'(r_z),   32'd0);
      chk("rst_r_ov",  32'(r_ov),  32'd0);
      chk("rst_r_cnt", 32'(r_cnt), 32'd0);
      chk("rst_c_cnt", 32'(c_cnt), 32'd0);

      {c_x, c_y} = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;

      // registered path: 1-cycle latency, then hold while in_valid=0
      r_vld = 1'b1; r_x = 4'b1010; r_y = 4'b0101;
      step();
      chk("reg_z",  32'(r_z),  32'hF);
      chk("reg_ov", 32'(r_ov), 32'd1);
      r_vld = 1'b0; r_x = 4'b0000; r_y = 4'b0011;
      step();
      chk("hold_z", 32'(r_z),  32'hF);
      chk("hold_ov", 32'(r_ov), 32'd0);

      // counter on the combinational instance: 3 rises, then clear beats a rise
      c_vld = 1'b1; c_clr = 1'b1;
      step();
      c_clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         c_x = 1'b0; step();
         c_x = 1'b1; step();
      end
      chk("cnt3", 32'(c_cnt), 32'd3);
      c_x = 1'b0; step();
      c_x = 1'b1; c_clr = 1'b1; step();
      chk("clr_wins", 32'(c_cnt), 32'd0);
      c_clr = 1'b0;

      // saturation on the 2-bit counter
      r_vld = 1'b1; r_y = 4'b0000; r_clr = 1'b1; r_x = 4'b0000;
      step();
      r_clr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         r_x = 4'b0000; step();
         r_x = 4'b0100; step();
      end
      r_x = 4'b0000; step(); step();
      chk("sat3", 32'(r_cnt), 32'd3);
      r_x = 4'b0001; step(); step();
      chk("sat_hold", 32'(r_cnt), 32'd3);

      // asynchronous reset between edges
      c_x = 1'b1; c_y = 1'b1; c_vld = 1'b1;
      r_x = 4'b1111; r_y = 4'b1111; r_vld = 1'b1;
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("arst_r_z",   32'(r_z),   32'd0);
      chk("arst_r_ov",  32'(r_ov),  32'd0);
      chk("arst_r_cnt", 32'(r_cnt), 32'd0);
      chk("arst_c_cnt", 32'(c_cnt), 32'd0);
      chk("arst_c_z",   32'(c_z),   32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("first_rise", 32'(c_cnt), 32'd1);
      step(); step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         c_vld = 1'($urandom);
         c_x   = 1'($urandom_range(0, 3) == 0);
         c_y   = 1'($urandom_range(0, 3) == 0);
         c_clr = 1'($urandom_range(0, 15) == 0);
         r_vld = 1'($urandom);
         r_x   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         r_y   = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         r_clr = 1'($urandom_range(0, 15) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/or_gate_db.md
Name: or_gate_db

Overview:
- Parameterised bitwise two-input OR block with optional output register, output-valid tracking and a saturating rising-edge event counter on the reduced result.
- Used as a basic logic primitive and as a glitch-free, registered OR stage in datapaths.
- At default parameters the z path is purely combinational (z = x | y), so an unclocked bench stepping x/y every 10 ns sees the OR truth table directly.

Parameters:
- WIDTH, 1, bit width of x, y, z.
- OUT_REG, 0, 0 = z combinational; 1 = z registered (1-cycle latency).
- CNT_W, 8, width of rise_cnt.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies x/y for the registered path and the counter.
- x  input  WIDTH  operand A.
- y  input  WIDTH  operand B.
- z  output  WIDTH  bitwise OR result.
- out_valid  output  1  z holds a qualified result.
- z_any  output  1  reduction OR of z.
- rise_cnt  output  CNT_W  count of z_any 0->1 transitions, saturating.
- clr_cnt  input  1  synchronous clear of rise_cnt.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - OUT_REG=1: z register = 0.
  - out_valid = 0, rise_cnt = 0, internal z_any_prev = 0.
  - OUT_REG=0: z still follows x|y during reset; only the state elements clear.
- OUT_REG=0:
  - z = x | y combinationally, zero latency, independent of clk, rst_n and in_valid.
  - out_valid = in_valid, combinational.
- OUT_REG=1:
  - On each rising clk edge with in_valid=1: z <= x | y.
  - With in_valid=0: z holds its previous value.
  - out_valid <= in_valid, so it lags by exactly 1 cycle.
- z_any = |z, combinational from z, for both OUT_REG settings.
- Counter (always clocked):
  - z_any_prev <= z_any on every edge.
  - A rise is z_any=1 and z_any_prev=0, sampled at the edge while out_valid=1.
  - On a rise, rise_cnt increments by 1.
  - rise_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_cnt=1 sets rise_cnt to 0 at the edge and has priority over a simultaneous rise.
- Reset asserted mid-operation aborts any pending update. The first edge after deassertion behaves as if z_any_prev=0.
- All outputs are free of X once rst_n has been low, provided inputs are known.
- Width rules: no arithmetic on x/y. The counter is unsigned CNT_W-bit.

Decomposition:
- Shared package or_gate_db_pkg holds:
  - default constants DEF_WIDTH=1, DEF_CNT_W=8;
  - a localparam function for the saturation value (all-ones of CNT_W).
- One natural sub-module: or_gate_db_edge_cnt. It implements edge detect plus the saturating counter with clear.
- The OR datapath and the optional register remain in the top module.

Test Plan:
- Default params, no clock: x,y = 00, 01, 10, 11 at 10 ns steps -> z = 0, 1, 1, 1 each within the same timestep.
- OUT_REG=1, WIDTH=4, in_valid=1: x=4'b1010, y=4'b0101 -> z=4'b1111 and out_valid=1 one cycle later. Then in_valid=0 with new x/y -> z holds 4'b1111.
- Counter: alternate (x,y)=(0,0) and (1,0) for 3 full periods with out_valid=1 -> rise_cnt=3. Pulse clr_cnt during a rise -> rise_cnt=0.
- Saturation, CNT_W=2: 5 rises -> rise_cnt=3, stays 3.
- Asynchronous reset mid-run: drop rst_n between edges -> rise_cnt=0, out_valid=0, registered z=0 immediately. With (x,y)=(1,1) held, the first edge after release counts 1 rise.
